// File: rtl/key_event_queue.sv
// key_event_queue -- PS/2 scan-code set 2 decoder feeding an event FIFO.
//
// Consumes bytes from a PS/2 receiver, folds E0/F0 prefixes into 10-bit
// events {brk, e0, code}, tracks which keys are held, derives live modifier
// state and buffers events in a first-word-fall-through FIFO.
//
// Optional feature: define KEY_REPEAT_EN to compile in a typematic repeat
// generator.
//   Without it, every decoded event is pushed.
//   With it, keyboard-generated repeat makes are suppressed and repeats are
//   synthesised internally.
//
// Ports
//   clk, clrn          rising-edge clock, synchronous active-low reset
//   ps2_data[7:0]      received byte
//   ps2_ready          receiver holds a byte
//   nextdata_n         active-low one-cycle acknowledge of a consumed byte
//   rd_en              pop head event (ignored while empty)
//   ev_valid           FIFO non-empty
//   ev_data[9:0]       head event {brk, e0, code}; zero while empty
//   ev_count           FIFO occupancy, 0..DEPTH
//   overflow, ovf_clr  sticky event-lost flag and its clear
//   shift/ctrl/alt     live modifier state from the key table
//   capslock           toggles on each fresh make of plain 0x58
//   dbg_state          decoder state, for observation only
//
// Handshake: a byte is taken in any cycle where ps2_ready=1 and
// nextdata_n=1. nextdata_n then goes low for exactly the next cycle, and no
// byte is taken while it is low.
module key_event_queue #(
    parameter int DEPTH         = 16,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [7:0]             ps2_data,
    input  logic                   ps2_ready,
    output logic                   nextdata_n,
    input  logic                   rd_en,
    output logic                   ev_valid,
    output logic [9:0]             ev_data,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   shift,
    output logic                   ctrl,
    output logic                   alt,
    output logic                   capslock,
    output logic [1:0]             dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} dec_state_t;

    dec_state_t state_q, state_d;
    logic       consume, emit;
    logic [9:0] dec_ev;
    logic [8:0] key_idx;
    logic       held, is_make, dec_push;
    logic [511:0] key_q;
    logic       caps_q;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          full, empty, push_req, do_push, do_pop, ovf_set;
    logic [9:0]    push_data;

    assign consume = ps2_ready & nextdata_n;

    // Decoder next state; the event is formed from the current prefix state.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        dec_ev  = {(state_q == GOT_F0) || (state_q == GOT_E0F0),
                   (state_q == GOT_E0) || (state_q == GOT_E0F0),
                   ps2_data};
        if (consume) begin
            unique case (state_q)
                IDLE: begin
                    if (ps2_data == 8'hE0)      state_d = GOT_E0;
                    else if (ps2_data == 8'hF0) state_d = GOT_F0;
                    else                        emit = 1'b1;
                end
                GOT_E0: begin
                    if (ps2_data == 8'hE0)      state_d = GOT_E0;
                    else if (ps2_data == 8'hF0) state_d = GOT_E0F0;
                    else                        emit = 1'b1;
                end
                GOT_F0, GOT_E0F0: emit = 1'b1;
            endcase
            if (emit) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q    <= IDLE;
            nextdata_n <= 1'b1;
        end else begin
            state_q    <= state_d;
            nextdata_n <= ~consume;
        end
    end

    assign dbg_state = state_q;
    assign key_idx   = dec_ev[8:0];
    assign held      = key_q[key_idx];
    assign is_make   = emit & ~dec_ev[9];

    // Key table and capslock; the table follows the keyboard even when the
    // event itself is lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            key_q  <= '0;
            caps_q <= 1'b0;
        end else begin
            if (emit) key_q[key_idx] <= ~dec_ev[9];
            if (is_make && !held && key_idx == 9'h058) caps_q <= ~caps_q;
        end
    end

    assign shift    = key_q[9'h012] | key_q[9'h059];
    assign ctrl     = key_q[9'h014] | key_q[9'h114];
    assign alt      = key_q[9'h011] | key_q[9'h111];
    assign capslock = caps_q;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(RMAX + 1);

    logic          rep_active, rep_fire, rep_push, is_mod;
    logic [8:0]    rep_key;
    logic [CW-1:0] rep_cnt;

    assign is_mod   = (dec_ev[7:0] == 8'h12) || (dec_ev[7:0] == 8'h59) ||
                      (dec_ev[7:0] == 8'h14) || (dec_ev[7:0] == 8'h11) ||
                      (dec_ev[7:0] == 8'h58);
    // Keyboard repeats of an already-held key are dropped; we make our own.
    assign dec_push = emit & ~(is_make & held);
    assign rep_fire = rep_active && (rep_cnt == CW'(1));
    // A decoder push wins the write port; the repeat is simply skipped.
    assign rep_push = rep_fire & ~dec_push;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            rep_active <= 1'b0;
            rep_key    <= '0;
            rep_cnt    <= '0;
        end else begin
            if (rep_fire)        rep_cnt <= CW'(REPEAT_PERIOD);
            else if (rep_active) rep_cnt <= rep_cnt - CW'(1);
            if (is_make && !held) begin
                if (!is_mod) begin
                    rep_active <= 1'b1;
                    rep_key    <= key_idx;
                    rep_cnt    <= CW'(REPEAT_DELAY);
                end else begin
                    rep_active <= 1'b0;
                end
            end else if (emit && dec_ev[9] && key_idx == rep_key) begin
                rep_active <= 1'b0;
            end
        end
    end

    assign push_req  = dec_push | rep_push;
    assign push_data = dec_push ? dec_ev : {1'b0, rep_key};
`else
    assign dec_push  = emit;
    assign push_req  = dec_push;
    assign push_data = dec_ev;
`endif

    // FIFO. A pop frees a slot in the same cycle, so push+pop at full is legal.
    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_pop  = rd_en & ~empty;
    assign do_push = push_req & (~full | rd_en);
    // Only decoder events count as lost; a dropped repeat is harmless.
    assign ovf_set = dec_push & full & ~rd_en;

    always_ff @(posedge clk) begin
        if (clrn && do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign ev_count = count_q;
    assign ev_valid = ~empty;
    assign ev_data  = empty ? 10'd0 : mem[rd_ptr];
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue -- directed and randomized bench for key_event_queue.
// Builds with or without KEY_REPEAT_EN; the reference model follows suit.
module tb_key_event_queue;
    localparam int DEPTH  = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 4;

    // clock / reset
    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ps2_data = 8'h00;
    logic ps2_ready = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
    logic nextdata_n, ev_valid, overflow, shift, ctrl, alt, capslock;
    logic [9:0] ev_data;
    logic [$clog2(DEPTH):0] ev_count;
    logic [1:0] dbg_state;

    key_event_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
        .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .nextdata_n(nextdata_n), .rd_en(rd_en), .ev_valid(ev_valid),
        .ev_data(ev_data), .ev_count(ev_count), .overflow(overflow),
        .ovf_clr(ovf_clr), .shift(shift), .ctrl(ctrl), .alt(alt),
        .capslock(capslock), .dbg_state(dbg_state)
    );

    // scoreboard and reference model
    logic [9:0] exp_q[$];
    bit held [512];
    bit m_e0, m_f0, m_caps, m_ovf;
    int n_cmp = 0;
    int n_fail = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mod_code(input logic [7:0] c);
        return c == 8'h12 || c == 8'h59 || c == 8'h14 || c == 8'h11 || c == 8'h58;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        foreach (held[i]) held[i] = 1'b0;
        m_e0 = 0; m_f0 = 0; m_caps = 0; m_ovf = 0;
    endfunction

    // Prefix accumulator: E0/F0 collect until any other byte closes the event.
    task automatic model_byte(input logic [7:0] b, input bit pop);
        logic [9:0] ev;
        int idx;
        bit push;
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (b == 8'hE0 && !m_f0) m_e0 = 1;
        else if (b == 8'hF0 && !m_f0) m_f0 = 1;
        else begin
            ev = {m_f0, m_e0, b};
            idx = int'(ev[8:0]);
            push = 1;
            if (!m_f0) begin
`ifdef KEY_REPEAT_EN
                if (held[idx]) push = 0;
`endif
                if (idx == 'h058 && !held[idx]) m_caps = !m_caps;
                held[idx] = 1;
            end else begin
                held[idx] = 0;
            end
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(ev);
                else m_ovf = 1;
            end
            m_e0 = 0;
            m_f0 = 0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [9:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
        chk({tag, ".ev_count"}, 32'(ev_count), 32'(exp_q.size()));
        chk({tag, ".ev_valid"}, 32'(ev_valid), 32'(exp_q.size() != 0));
        chk({tag, ".ev_data"}, 32'(ev_data), 32'(head));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".shift"}, 32'(shift), 32'(held['h012] | held['h059]));
        chk({tag, ".ctrl"}, 32'(ctrl), 32'(held['h014] | held['h114]));
        chk({tag, ".alt"}, 32'(alt), 32'(held['h011] | held['h111]));
        chk({tag, ".capslock"}, 32'(capslock), 32'(m_caps));
    endtask

    // driver tasks: all start and end at a falling edge
    task automatic send_byte(input logic [7:0] b, input bit pop);
        int t = 0;
        while (nextdata_n !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ack_idle", 32'(nextdata_n), 32'd1);
        ps2_data = b;
        ps2_ready = 1'b1;
        rd_en = pop;
        @(posedge clk);
        model_byte(b, pop);
        @(negedge clk);
        ps2_ready = 1'b0;
        rd_en = 1'b0;
        chk("ack_pulse", 32'(nextdata_n), 32'd0);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 2 * DEPTH) begin
            pop_one();
            guard++;
        end
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(posedge clk);
        m_ovf = 0;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] c, input bit e0);
        if (e0) send_byte(8'hE0, 0);
        send_byte(c, 0);
    endtask

    task automatic release_key(input logic [7:0] c, input bit e0);
        if (e0) send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(c, 0);
    endtask

    initial begin
        logic [7:0] mod_codes [7];
        bit mod_e0 [7];
        logic [7:0] c;
        int sel, idx;
        mod_codes = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h14, 8'h11};
        mod_e0 = '{0, 0, 0, 0, 0, 1, 1};
        model_clear();

        // reset state
        wait_edges(3);
        check_state("reset");
        chk("reset.nextdata_n", 32'(nextdata_n), 32'd1);
        clrn = 1'b1;
        @(negedge clk);

        // make / break of a plain key
        send_byte(8'h1C, 0);
        chk("make_1c", 32'(ev_data), 32'h01C);
        check_state("make_1c");
        release_key(8'h1C, 0);
        check_state("break_1c");
        pop_one();
        chk("break_1c_head", 32'(ev_data), 32'h21C);
        drain();

        // extended ctrl
        press(8'h14, 1);
        chk("rctrl_on", 32'(ctrl), 32'd1);
        check_state("rctrl_make");
        release_key(8'h14, 1);
        chk("rctrl_off", 32'(ctrl), 32'd0);
        check_state("rctrl_break");
        pop_one();
        chk("rctrl_break_head", 32'(ev_data), 32'h314);
        drain();

        // pop while empty is ignored
        pop_one();
        check_state("pop_empty");

        // overflow, clear, then push+pop at full
        press(8'h12, 0);
        press(8'h59, 0);
        press(8'h14, 0);
        press(8'h11, 0);
        press(8'h14, 1);
        chk("ovf_count", 32'(ev_count), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        check_state("overflow");
        clear_ovf();
        check_state("ovf_clr");
        send_byte(8'hE0, 0);
        send_byte(8'h11, 1);
        chk("push_pop_full_ovf", 32'(overflow), 32'd0);
        check_state("push_pop_full");
        drain();
        release_key(8'h12, 0);
        release_key(8'h59, 0);
        release_key(8'h14, 0);
        drain();
        release_key(8'h11, 0);
        release_key(8'h14, 1);
        drain();
        release_key(8'h11, 1);
        drain();
        clear_ovf();
        check_state("mods_released");

        // capslock toggling
        press(8'h58, 0);
        chk("caps_on", 32'(capslock), 32'd1);
        release_key(8'h58, 0);
        drain();
        press(8'h58, 0);
        chk("caps_off", 32'(capslock), 32'd0);
        release_key(8'h58, 0);
        drain();
        press(8'h58, 0);
        press(8'h58, 0);
        chk("caps_no_retoggle", 32'(capslock), 32'd1);
        check_state("caps_repeat");
        release_key(8'h58, 0);
        drain();
        check_state("caps_done");

`ifdef KEY_REPEAT_EN
        // typematic: repeats at +10, +14, +18; break collides with the +22 repeat
        send_byte(8'h1C, 0);
        wait_edges(DELAY - 1);
        check_state("rep_before");
        wait_edges(1);
        exp_q.push_back(10'h01C);
        check_state("rep_first");
        wait_edges(PERIOD - 1);
        check_state("rep_gap");
        wait_edges(1);
        exp_q.push_back(10'h01C);
        check_state("rep_second");
        wait_edges(PERIOD);
        exp_q.push_back(10'h01C);
        check_state("rep_third");
        pop_one();
        release_key(8'h1C, 0);
        check_state("rep_collide");
        wait_edges(30);
        check_state("rep_stopped");
        drain();
`endif

        // reset in the middle of an E0 sequence with a byte presented
        send_byte(8'hE0, 0);
        clrn = 1'b0;
        ps2_data = 8'h1C;
        ps2_ready = 1'b1;
        wait_edges(2);
        model_clear();
        check_state("mid_reset");
        chk("mid_reset.nextdata_n", 32'(nextdata_n), 32'd1);
        ps2_ready = 1'b0;
        clrn = 1'b1;
        @(negedge clk);
        send_byte(8'h1C, 0);
        chk("post_reset_ev", 32'(ev_data), 32'h01C);
        release_key(8'h1C, 0);
        check_state("post_reset");
        drain();

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin
                    do c = 8'($urandom_range(1, 255));
                    while (c == 8'hE0 || c == 8'hF0 || is_mod_code(c));
                    idx = $urandom_range(0, 1);
                    press(c, idx[0]);
                    release_key(c, idx[0]);
                end
                1: begin
                    idx = $urandom_range(0, 6);
                    if (held[{mod_e0[idx], mod_codes[idx]}]) release_key(mod_codes[idx], mod_e0[idx]);
                    else press(mod_codes[idx], mod_e0[idx]);
                end
                2: pop_one();
                3: clear_ovf();
                default: begin
                    idx = $urandom_range(0, 6);
                    press(mod_codes[idx], mod_e0[idx]);
                end
            endcase
            wait_edges($urandom_range(0, 3));
            check_state("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
